// File: rtl/rf_wr_arbiter_pkg.sv
// rf_wr_arbiter_pkg: shared register-file widths and write-back grant sources
package rf_wr_arbiter_pkg;
    localparam int rf_data_width = 32;
    localparam int rf_sel_width = 5;
    typedef enum logic [1:0] {grant_none, grant_core, grant_fifo, grant_apu} grant_e;
endpackage

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: circular write-back buffer exposing per-entry valid/sel for hazard lookup
module rf_wr_fifo #(
    parameter int depth = 4,
    parameter int data_width = 32,
    parameter int sel_width = 5,
    localparam int pw = $clog2(depth),
    localparam int cw = pw + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic [sel_width-1:0]               push_sel,
    input  logic [data_width-1:0]              push_data,
    input  logic                               pop,
    output logic [sel_width-1:0]               head_sel,
    output logic [data_width-1:0]              head_data,
    output logic                               full,
    output logic                               empty,
    output logic [cw-1:0]                      count,
    output logic [depth-1:0]                   entry_valid,
    output logic [depth-1:0][sel_width-1:0]    entry_sel
);
    logic [pw-1:0] rd_ptr, wr_ptr;
    logic [sel_width-1:0] mem_sel [depth];
    logic [data_width-1:0] mem_data [depth];
    logic do_push, do_pop;

    assign full = count == cw'(depth);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head_sel = mem_sel[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // pointers wrap naturally because depth is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + cw'(do_push) - cw'(do_pop);
        end
    end

    // storage needs no reset; validity comes from the pointers and count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_sel[wr_ptr] <= push_sel;
            mem_data[wr_ptr] <= push_data;
        end
    end

    for (genvar g = 0; g < depth; g++) begin : g_entry
        logic [pw-1:0] off;
        assign off = pw'(g) - rd_ptr;
        assign entry_valid[g] = cw'(off) < count;
        assign entry_sel[g] = mem_sel[g];
    end
endmodule

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: core-priority write-back arbiter with in-order APU buffer and RAW lookup
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int data_width = rf_data_width,
    parameter int reg_sel_width = rf_sel_width,
    parameter int apu_fifo_depth = 4,
    localparam int cw = $clog2(apu_fifo_depth) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_wr_req,
    input  logic [reg_sel_width-1:0] core_wr_sel,
    input  logic [data_width-1:0]    core_wr_data,
    input  logic                     apu_wr_req,
    input  logic [reg_sel_width-1:0] apu_wr_sel,
    input  logic [data_width-1:0]    apu_wr_data,
    output logic                     apu_wr_stall,
    output logic                     overflow,
    input  logic [reg_sel_width-1:0] query_sel,
    output logic                     query_pending,
    output logic                     rf_wr_req,
    output logic [reg_sel_width-1:0] rf_wr_sel,
    output logic [data_width-1:0]    rf_wr_data
);
    logic core_v, apu_v, push, pop, fifo_full, fifo_empty, out_apu, hit;
    logic [reg_sel_width-1:0] head_sel, win_sel;
    logic [data_width-1:0] head_data, win_data;
    logic [cw-1:0] count;
    logic [apu_fifo_depth-1:0] entry_valid;
    logic [apu_fifo_depth-1:0][reg_sel_width-1:0] entry_sel;
    grant_e grant;

    assign core_v = core_wr_req && core_wr_sel != '0;
    assign apu_v = apu_wr_req && apu_wr_sel != '0;
    assign pop = grant == grant_fifo;
    assign push = apu_v && grant != grant_apu;
    assign win_sel = grant == grant_core ? core_wr_sel : grant == grant_fifo ? head_sel : apu_wr_sel;
    assign win_data = grant == grant_core ? core_wr_data : grant == grant_fifo ? head_data : apu_wr_data;
    assign apu_wr_stall = count >= cw'(apu_fifo_depth - 1);

    rf_wr_fifo #(
        .depth(apu_fifo_depth),
        .data_width(data_width),
        .sel_width(reg_sel_width)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .push_sel(apu_wr_sel),
        .push_data(apu_wr_data),
        .pop(pop),
        .head_sel(head_sel),
        .head_data(head_data),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(count),
        .entry_valid(entry_valid),
        .entry_sel(entry_sel)
    );

    // core first, then oldest buffered APU write, then a direct APU bypass
    always_comb begin
        grant = core_v ? grant_core : !fifo_empty ? grant_fifo : apu_v ? grant_apu : grant_none;
    end

    // output register remembers whether the presented write came from the APU
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wr_req <= 1'b0;
            rf_wr_sel <= '0;
            rf_wr_data <= '0;
            out_apu <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rf_wr_req <= grant != grant_none;
            out_apu <= grant == grant_fifo || grant == grant_apu;
            if (grant != grant_none) begin
                rf_wr_sel <= win_sel;
                rf_wr_data <= win_data;
            end
            overflow <= overflow || (push && fifo_full && !pop);
        end
    end

    // any buffered or presented APU write to the queried register is a hazard
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < apu_fifo_depth; i++) hit = hit || (entry_valid[i] && entry_sel[i] == query_sel);
        query_pending = query_sel != '0 && (hit || (rf_wr_req && out_apu && rf_wr_sel == query_sel));
    end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed stimulus checked against a queue-based write-back model
module tb_rf_wr_arbiter;
    localparam int dw = 32;
    localparam int sw = 5;
    localparam int depth = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic core_wr_req = 1'b0, apu_wr_req = 1'b0;
    logic [sw-1:0] core_wr_sel = '0, apu_wr_sel = '0, query_sel = '0;
    logic [dw-1:0] core_wr_data = '0, apu_wr_data = '0;
    logic apu_wr_stall, overflow, query_pending, rf_wr_req;
    logic [sw-1:0] rf_wr_sel;
    logic [dw-1:0] rf_wr_data;
    int total = 0;
    int bad = 0;
    bit run = 1'b0;

    rf_wr_arbiter #(.data_width(dw), .reg_sel_width(sw), .apu_fifo_depth(depth)) dut (
        .clk(clk),
        .rst(rst),
        .core_wr_req(core_wr_req),
        .core_wr_sel(core_wr_sel),
        .core_wr_data(core_wr_data),
        .apu_wr_req(apu_wr_req),
        .apu_wr_sel(apu_wr_sel),
        .apu_wr_data(apu_wr_data),
        .apu_wr_stall(apu_wr_stall),
        .overflow(overflow),
        .query_sel(query_sel),
        .query_pending(query_pending),
        .rf_wr_req(rf_wr_req),
        .rf_wr_sel(rf_wr_sel),
        .rf_wr_data(rf_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [sw-1:0] sel;
        logic [dw-1:0] data;
    } wr_t;

    wr_t mq[$];
    logic m_req = 1'b0, m_apu = 1'b0, m_ovf = 1'b0;
    logic [sw-1:0] m_sel = '0;
    logic [dw-1:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_pending(input logic [sw-1:0] q);
        logic h;
        h = m_req && m_apu && m_sel == q;
        foreach (mq[i]) h = h || mq[i].sel == q;
        return q != '0 && h;
    endfunction

    // model: core wins, then oldest queued APU write, then APU bypass; losers queue or drop
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_req = 1'b0; m_apu = 1'b0; m_ovf = 1'b0; m_sel = '0; m_data = '0;
        end else begin
            automatic logic cv = core_wr_req && core_wr_sel != 0;
            automatic logic av = apu_wr_req && apu_wr_sel != 0;
            automatic logic byp = 1'b0;
            automatic wr_t w;
            m_req = 1'b1;
            if (cv) begin
                m_sel = core_wr_sel; m_data = core_wr_data; m_apu = 1'b0;
            end else if (mq.size() > 0) begin
                w = mq.pop_front();
                m_sel = w.sel; m_data = w.data; m_apu = 1'b1;
            end else if (av) begin
                m_sel = apu_wr_sel; m_data = apu_wr_data; m_apu = 1'b1; byp = 1'b1;
            end else begin
                m_req = 1'b0; m_apu = 1'b0;
            end
            if (av && !byp) begin
                if (mq.size() < depth) begin
                    w.sel = apu_wr_sel; w.data = apu_wr_data;
                    mq.push_back(w);
                end else m_ovf = 1'b1;
            end
        end
    end

    // cycle-by-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (rst && run) begin
            chk("cyc_req", 32'(rf_wr_req), 32'(m_req));
            chk("cyc_sel", 32'(rf_wr_sel), 32'(m_sel));
            chk("cyc_data", rf_wr_data, m_data);
            chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
            chk("cyc_stall", 32'(apu_wr_stall), 32'(mq.size() >= depth - 1));
            chk("cyc_pending", 32'(query_pending), 32'(exp_pending(query_sel)));
        end
    end

    task automatic drive(input logic cr, input logic [sw-1:0] cs, input logic [dw-1:0] cd,
                         input logic ar, input logic [sw-1:0] as, input logic [dw-1:0] ad);
        core_wr_req = cr; core_wr_sel = cs; core_wr_data = cd;
        apu_wr_req = ar; apu_wr_sel = as; apu_wr_data = ad;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #12;
        chk("rst_req", 32'(rf_wr_req), 0);
        chk("rst_sel", 32'(rf_wr_sel), 0);
        chk("rst_data", rf_wr_data, 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_stall", 32'(apu_wr_stall), 0);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h1234);
        chk("bypass_req", 32'(rf_wr_req), 1);
        chk("bypass_sel", 32'(rf_wr_sel), 5);
        chk("bypass_data", rf_wr_data, 32'h1234);
        idle();
        chk("bypass_after_req", 32'(rf_wr_req), 0);
        chk("bypass_hold_sel", 32'(rf_wr_sel), 5);
        query_sel = 5'd7;
        drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd7, 32'hBB);
        chk("clash_core_sel", 32'(rf_wr_sel), 3);
        chk("clash_core_data", rf_wr_data, 32'hAA);
        chk("clash_pending_t1", 32'(query_pending), 1);
        idle();
        chk("clash_apu_sel", 32'(rf_wr_sel), 7);
        chk("clash_apu_data", rf_wr_data, 32'hBB);
        chk("clash_pending_t2", 32'(query_pending), 1);
        idle();
        chk("clash_done_req", 32'(rf_wr_req), 0);
        chk("clash_pending_t3", 32'(query_pending), 0);
        query_sel = '0;
        drive(1'b1, '0, 32'h55, 1'b1, '0, 32'h66);
        chk("x0_req", 32'(rf_wr_req), 0);
        chk("x0_stall", 32'(apu_wr_stall), 0);
        chk("x0_pending", 32'(query_pending), 0);
        idle();
        chk("x0_nothing_queued", 32'(rf_wr_req), 0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, sw'(1 + i), dw'(32'h100 + i), i < 3, i < 3 ? sw'(10 + i) : '0, dw'(32'h200 + i));
            if (i == 1) chk("burst_stall_at2", 32'(apu_wr_stall), 0);
            if (i == 2) chk("burst_stall_at3", 32'(apu_wr_stall), 1);
        end
        chk("burst_last_core", 32'(rf_wr_sel), 6);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("burst_drain_req", 32'(rf_wr_req), 1);
            chk("burst_drain_sel", 32'(rf_wr_sel), 32'(10 + k));
        end
        chk("burst_overflow", 32'(overflow), 0);
        idle();
        chk("burst_empty_req", 32'(rf_wr_req), 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, sw'(1 + i), dw'(32'h400 + i), i < 5, i < 5 ? sw'(20 + i) : '0, dw'(32'h300 + i));
            if (i == 3) chk("full_no_overflow", 32'(overflow), 0);
            if (i == 4) chk("full_overflow", 32'(overflow), 1);
        end
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("full_drain_sel", 32'(rf_wr_sel), 32'(20 + k));
            chk("full_drain_data", rf_wr_data, 32'h300 + 32'(k));
        end
        idle();
        chk("full_dropped_absent", 32'(rf_wr_req), 0);
        chk("full_overflow_sticky", 32'(overflow), 1);
        for (int i = 0; i < 4; i++)
            drive(1'b1, sw'(1 + i), dw'(32'h500 + i), i < 3, i < 3 ? sw'(13 + i) : '0, dw'(32'h600 + i));
        query_sel = 5'd14;
        idle();
        chk("drain_first_sel", 32'(rf_wr_sel), 13);
        chk("drain_pending", 32'(query_pending), 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_req", 32'(rf_wr_req), 0);
        chk("midrst_sel", 32'(rf_wr_sel), 0);
        chk("midrst_data", rf_wr_data, 0);
        chk("midrst_stall", 32'(apu_wr_stall), 0);
        chk("midrst_overflow", 32'(overflow), 0);
        chk("midrst_pending", 32'(query_pending), 0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("postrst_req", 32'(rf_wr_req), 0);
        end
        chk("postrst_overflow", 32'(overflow), 0);
        chk("postrst_pending", 32'(query_pending), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Write-back arbiter between the register file's single write port and its two producers.
- Core integer pipeline writes are single-cycle and cannot stall.
- APU writes (divider and other multi-cycle units) are single-cycle pulses with no backpressure on the write itself.
- Core writes win. APU writes that lose are held in a small in-order FIFO and drained when the core port is idle. The block also exposes a pending-write lookup for the issue stage's RAW hazard check.

Parameters:
- data_width, 32, register data width
- reg_sel_width, 5, register index width
- apu_fifo_depth, 4, APU write buffer entries (power of 2, >= 2)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- core_wr_req  input  1  core write strobe
- core_wr_sel  input  reg_sel_width  core destination register
- core_wr_data  input  data_width  core write data
- apu_wr_req  input  1  APU write strobe
- apu_wr_sel  input  reg_sel_width  APU destination register
- apu_wr_data  input  data_width  APU write data
- apu_wr_stall  output  1  FIFO near full; issue stage must hold new APU requests
- overflow  output  1  sticky error: an APU write was dropped
- query_sel  input  reg_sel_width  register index checked by issue stage
- query_pending  output  1  an APU write to query_sel is buffered or in the output register
- rf_wr_req  output  1  register-file write strobe
- rf_wr_sel  output  reg_sel_width  register-file write index
- rf_wr_data  output  data_width  register-file write data

Behaviour:
- Reset (async, rst low): rf_wr_req=0, rf_wr_sel=0, rf_wr_data=0, overflow=0, FIFO empty (pointers and count = 0), apu_wr_stall=0.
- Reset mid-drain discards all buffered writes immediately.
- x0 filtering: any write with sel==0 is ignored on either port. It is never granted, never enqueued, and never counts toward overflow.
- Grant order, evaluated each cycle, first match wins:
  - (1) valid core write.
  - (2) FIFO head if FIFO not empty; dequeue it.
  - (3) valid APU write, taken directly (bypass).
- Winner is registered. rf_wr_req/sel/data present it at cycle t+1 for one cycle. rf_wr_req=0 when nothing is granted; sel/data then hold their previous values.
- A valid APU write not taken by bypass is enqueued the same cycle, at the tail.
- APU writes are never bypassed past older FIFO entries, so APU order is preserved.
- Latencies:
  - APU with empty FIFO and idle core: 1 cycle.
  - Otherwise: 1 + (cycles core stays busy) + (entries ahead).
- FIFO:
  - Circular buffer; read/write pointers wrap modulo apu_fifo_depth.
  - count ranges 0..apu_fifo_depth.
  - Enqueue and dequeue in the same cycle: count unchanged. This is legal when full, because the dequeue frees the slot first.
- Full boundary: an enqueue when count==depth with no dequeue that cycle drops the write. overflow is set and stays 1 until reset; FIFO contents are unchanged.
- apu_wr_stall = (count >= apu_fifo_depth-1). Derived combinationally from the count register only, with no input dependency.
- query_pending is combinational. It is 1 when query_sel != 0 and it matches either:
  - any valid FIFO entry, or
  - the output register while rf_wr_req=1 and that output came from the APU.
  - Track the source with a 1-bit output-register flag, which resets to 0.
- WAW ordering between core and APU writes to the same register is prevented upstream by the issue stage using query_pending. The arbiter does not reorder or squash such writes.

Decomposition:
- Shared package holds data_width and reg_sel_width constants, already used by apu and the register file.
- One sub-module: rf_wr_fifo, a parameterised sync FIFO with:
  - push/pop/full/empty/count ports;
  - an exposed entry-valid vector plus per-entry sel array, for the query_pending compare.
- The arbiter top holds the grant mux, output register, overflow flag and query logic.

Test Plan:
- APU sel=5 data=0x1234 at cycle t, FIFO empty, core idle -> t+1: rf_wr_req=1, sel=5, data=0x1234; t+2: rf_wr_req=0.
- Core sel=3 data=0xAA and APU sel=7 data=0xBB both at t -> t+1: sel=3 data=0xAA; t+2: sel=7 data=0xBB. query_sel=7 gives query_pending=1 during t+1 and t+2, and 0 at t+3.
- Core writes sel=1..6 on six consecutive cycles while APU writes sel=10,11,12 on the first three -> apu_wr_stall rises when count reaches 3. After the core burst, rf outputs sel=10,11,12 in order on consecutive cycles; overflow stays 0.
- depth=4, core busy 8 cycles, APU writes sel=20..24 on 5 consecutive cycles -> fifth write dropped, overflow=1 (sticky). Drain outputs sel 20,21,22,23 only.
- Core sel=0 and APU sel=0 in the same cycle -> rf_wr_req stays 0, count stays 0, query_sel=0 gives query_pending=0.
- FIFO holding 3 entries, rst pulsed low mid-drain -> all outputs 0 immediately. After release: count=0, no further rf_wr_req, overflow=0.
